// File: rtl/glitch_cmd_parser.sv
// Framed multi-channel command decoder: opcode, channel, delay/width body, optional checksum.
// Optional trailing XOR checksum byte is enabled by defining GLITCH_CMD_CHECKSUM_EN.
module glitch_cmd_parser #(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned DELAY_BYTES    = 2,
  parameter int unsigned WIDTH_BYTES    = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic [NUM_CH-1:0]             glitch_en,
  output logic [NUM_CH*8*DELAY_BYTES-1:0] delay_out,
  output logic [NUM_CH*8*WIDTH_BYTES-1:0] width_out,
  output logic                          busy,
  output logic                          err
);

  localparam int unsigned DELAY_W  = 8 * DELAY_BYTES;
  localparam int unsigned WIDTH_W  = 8 * WIDTH_BYTES;
  localparam int unsigned MaxBytes = (DELAY_BYTES > WIDTH_BYTES) ? DELAY_BYTES : WIDTH_BYTES;
  localparam int unsigned CntW     = (MaxBytes > 1) ? $clog2(MaxBytes) : 1;
  localparam int unsigned TmoW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] DelayLast = CntW'(DELAY_BYTES - 1);
  localparam logic [CntW-1:0] WidthLast = CntW'(WIDTH_BYTES - 1);
  localparam logic [TmoW-1:0] TmoLast   = TmoW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [8:0]      NumChW    = 9'(NUM_CH);

  typedef enum logic [2:0] {
    StIdle, StChan, StDelay, StWidth, StCsum, StCommit
  } state_e;

  typedef enum logic [1:0] {
    OpLoadFire = 2'd0,
    OpLoad     = 2'd1,
    OpFire     = 2'd2
  } op_e;

  state_e                    state_q, state_d;
  op_e                       op_q, op_d;
  logic [7:0]                ch_q, ch_d;
  logic                      bad_q, bad_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [TmoW-1:0]           tmo_q, tmo_d;
  logic [DELAY_W-1:0]        delay_sh_q, delay_sh_d;
  logic [WIDTH_W-1:0]        width_sh_q, width_sh_d;
  logic [NUM_CH-1:0]         glitch_en_q, glitch_en_d;
  logic [NUM_CH*DELAY_W-1:0] delay_q, delay_d;
  logic [NUM_CH*WIDTH_W-1:0] width_q, width_d;
  logic                      err_q, err_d;
`ifdef GLITCH_CMD_CHECKSUM_EN
  logic [7:0]                csum_q, csum_d;
`endif

  logic commit;
  logic bad_fin;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ch_d        = ch_q;
    bad_d       = bad_q;
    cnt_d       = cnt_q;
    delay_sh_d  = delay_sh_q;
    width_sh_d  = width_sh_q;
    glitch_en_d = '0;
    delay_d     = delay_q;
    width_d     = width_q;
    err_d       = 1'b0;
    commit      = 1'b0;
    bad_fin     = bad_q;
`ifdef GLITCH_CMD_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    unique case (state_q)
      // COMMIT lasts one cycle and accepts the next opcode exactly like IDLE.
      StIdle, StCommit: begin
        state_d = StIdle;
        if (rx_valid && rx_data <= 8'h02) begin
          state_d    = StChan;
          op_d       = op_e'(rx_data[1:0]);
          bad_d      = 1'b0;
          cnt_d      = '0;
          delay_sh_d = '0;
          width_sh_d = '0;
`ifdef GLITCH_CMD_CHECKSUM_EN
          csum_d     = rx_data;
`endif
        end
      end
      StChan: begin
        if (rx_valid) begin
          ch_d  = rx_data;
          bad_d = ({1'b0, rx_data} >= NumChW);
`ifdef GLITCH_CMD_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (op_q == OpFire) begin
`ifdef GLITCH_CMD_CHECKSUM_EN
            state_d = StCsum;
`else
            commit  = 1'b1;
            bad_fin = bad_d;
`endif
          end else begin
            state_d = StDelay;
            cnt_d   = '0;
          end
        end
      end
      StDelay: begin
        if (rx_valid) begin
          delay_sh_d = (delay_sh_q << 8) | DELAY_W'(rx_data);
`ifdef GLITCH_CMD_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (cnt_q == DelayLast) begin
            cnt_d   = '0;
            state_d = StWidth;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StWidth: begin
        if (rx_valid) begin
          width_sh_d = (width_sh_q << 8) | WIDTH_W'(rx_data);
`ifdef GLITCH_CMD_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (cnt_q == WidthLast) begin
            cnt_d = '0;
`ifdef GLITCH_CMD_CHECKSUM_EN
            state_d = StCsum;
`else
            commit  = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StCsum: begin
`ifdef GLITCH_CMD_CHECKSUM_EN
        if (rx_valid) begin
          commit  = 1'b1;
          bad_fin = bad_q | (rx_data != csum_q);
        end
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase

    if (commit) begin
      state_d = StCommit;
      if (bad_fin) begin
        err_d = 1'b1;
      end else begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (ch_d == 8'(k)) begin
            if (op_q != OpFire) begin
              delay_d[k*DELAY_W +: DELAY_W] = delay_sh_d;
              width_d[k*WIDTH_W +: WIDTH_W] = width_sh_d;
            end
            if (op_q != OpLoad) glitch_en_d[k] = 1'b1;
          end
        end
      end
    end

    if (rx_valid || state_q == StIdle || state_q == StCommit) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    // A byte arriving on the expiry cycle wins over the timeout.
    if (TIMEOUT_CYCLES > 0 && !rx_valid && state_q != StIdle && state_q != StCommit &&
        tmo_q == TmoLast) begin
      state_d    = StIdle;
      err_d      = 1'b1;
      tmo_d      = '0;
      bad_d      = 1'b0;
      cnt_d      = '0;
      delay_sh_d = '0;
      width_sh_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= OpLoadFire;
      ch_q        <= '0;
      bad_q       <= 1'b0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      delay_sh_q  <= '0;
      width_sh_q  <= '0;
      glitch_en_q <= '0;
      delay_q     <= '0;
      width_q     <= '0;
      err_q       <= 1'b0;
`ifdef GLITCH_CMD_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ch_q        <= ch_d;
      bad_q       <= bad_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      delay_sh_q  <= delay_sh_d;
      width_sh_q  <= width_sh_d;
      glitch_en_q <= glitch_en_d;
      delay_q     <= delay_d;
      width_q     <= width_d;
      err_q       <= err_d;
`ifdef GLITCH_CMD_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign glitch_en = glitch_en_q;
  assign delay_out = delay_q;
  assign width_out = width_q;
  assign err       = err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_glitch_cmd_parser.sv
// Directed self-checking bench for glitch_cmd_parser with default parameters.
module tb_glitch_cmd_parser;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [1:0]  glitch_en;
  logic [31:0] delay_out;
  logic [15:0] width_out;
  logic        busy;
  logic        err;

  int errors = 0;
  int checks = 0;

  glitch_cmd_parser dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .glitch_en (glitch_en),
    .delay_out (delay_out),
    .width_out (width_out),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte is sampled at the next rising edge; returns 1 time unit after that edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Sends n bytes MSB first from f, appending the XOR checksum when the feature is built in.
  task automatic send_frame(input logic [47:0] f, input int n);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = f[8*(n-1-i) +: 8];
      x = x ^ b;
      send_byte(b);
    end
`ifdef GLITCH_CMD_CHECKSUM_EN
    send_byte(x);
`endif
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({glitch_en, delay_out, width_out, busy, err} !== 52'd0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b d=%h w=%h busy=%b err=%b, want all 0",
               glitch_en, delay_out, width_out, busy, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_load_fire;
    send_byte(8'h00);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL lf_busy_rise: got %b want 1", busy);
    end
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    checks++;
    if (glitch_en !== 2'b10 || err !== 1'b0) begin
      errors++;
      $display("FAIL lf_pulse: got en=%b err=%b want en=10 err=0", glitch_en, err);
    end
    checks++;
    if (delay_out !== 32'h1234_0000 || width_out !== 16'h5600) begin
      errors++;
      $display("FAIL lf_params: got d=%h w=%h want d=12340000 w=5600", delay_out, width_out);
    end
    step();
    checks++;
    if (glitch_en !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL lf_after: got en=%b busy=%b want en=00 busy=0", glitch_en, busy);
    end
  endtask

  task automatic test_load_then_fire;
    send_frame(48'h01_00_00_0A_05, 5);
    checks++;
    if (glitch_en !== 2'b00 || delay_out !== 32'h1234_000A || width_out !== 16'h5605) begin
      errors++;
      $display("FAIL load_only: got en=%b d=%h w=%h want en=00 d=1234000a w=5605",
               glitch_en, delay_out, width_out);
    end
    step();
    send_frame(48'h02_00, 2);
    checks++;
    if (glitch_en !== 2'b01 || delay_out !== 32'h1234_000A || width_out !== 16'h5605) begin
      errors++;
      $display("FAIL fire_stored: got en=%b d=%h w=%h want en=01 d=1234000a w=5605",
               glitch_en, delay_out, width_out);
    end
    step();
  endtask

  task automatic test_bad_channel;
    send_frame(48'h00_07_AA_BB_CC, 5);
    checks++;
    if (err !== 1'b1 || glitch_en !== 2'b00) begin
      errors++;
      $display("FAIL badch_err: got err=%b en=%b want err=1 en=00", err, glitch_en);
    end
    checks++;
    if (delay_out !== 32'h1234_000A || width_out !== 16'h5605) begin
      errors++;
      $display("FAIL badch_hold: got d=%h w=%h want d=1234000a w=5605", delay_out, width_out);
    end
    // Next opcode lands in the COMMIT cycle of the rejected frame.
    send_frame(48'h00_00_00_01_02, 5);
    checks++;
    if (glitch_en !== 2'b01 || err !== 1'b0 || delay_out !== 32'h1234_0001 ||
        width_out !== 16'h5602) begin
      errors++;
      $display("FAIL b2b_after_bad: got en=%b err=%b d=%h w=%h want en=01 err=0 d=12340001 w=5602",
               glitch_en, err, delay_out, width_out);
    end
    step();
  endtask

  task automatic test_timeout;
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h12);
    repeat (999) step();
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_early: got err=%b busy=%b want err=0 busy=1", err, busy);
    end
    step();
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_fire: got err=%b busy=%b want err=1 busy=0", err, busy);
    end
    step();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_pulse_width: got err=%b want 0", err);
    end
    send_frame(48'h00_01_AB_CD_EF, 5);
    checks++;
    if (glitch_en !== 2'b10 || delay_out !== 32'hABCD_0001 || width_out !== 16'hEF02) begin
      errors++;
      $display("FAIL tmo_recover: got en=%b d=%h w=%h want en=10 d=abcd0001 w=ef02",
               glitch_en, delay_out, width_out);
    end
    step();
  endtask

  task automatic test_reset_mid_frame;
    send_byte(8'h00);
    send_byte(8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({glitch_en, delay_out, width_out, busy, err} !== 52'd0) begin
      errors++;
      $display("FAIL async_reset: got en=%b d=%h w=%h busy=%b err=%b want all 0",
               glitch_en, delay_out, width_out, busy, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    send_frame(48'h01_01_00_07_09, 5);
    checks++;
    if (glitch_en !== 2'b00 || delay_out !== 32'h0007_0000 || width_out !== 16'h0900) begin
      errors++;
      $display("FAIL post_reset_frame: got en=%b d=%h w=%h want en=00 d=00070000 w=0900",
               glitch_en, delay_out, width_out);
    end
    step();
  endtask

  task automatic test_ignore_bad_opcode;
    send_byte(8'h7F);
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL bad_opcode: got busy=%b err=%b want busy=0 err=0", busy, err);
    end
  endtask

`ifdef GLITCH_CMD_CHECKSUM_EN
  task automatic test_checksum;
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h30);
    checks++;
    if (glitch_en !== 2'b01 || err !== 1'b0 || delay_out !== 32'h0007_0010 ||
        width_out !== 16'h0920) begin
      errors++;
      $display("FAIL csum_good: got en=%b err=%b d=%h w=%h want en=01 err=0 d=00070010 w=0920",
               glitch_en, err, delay_out, width_out);
    end
    step();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h31);
    checks++;
    if (glitch_en !== 2'b00 || err !== 1'b1) begin
      errors++;
      $display("FAIL csum_bad: got en=%b err=%b want en=00 err=1", glitch_en, err);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_load_fire();
    test_load_then_fire();
    test_bad_channel();
    test_timeout();
    test_reset_mid_frame();
    test_ignore_bad_opcode();
`ifdef GLITCH_CMD_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
